led_matrix_scanner: RTL and testbench

- Time-multiplexed row-scan driver for the bicolour (red/green) note-lane LED matrix; successor to the static lane-to-array mapping, generalised in rows, columns and lane count.
- Captures lane bitmaps and score once per frame into a shadow buffer (tear-free) and scans one row at a time with anti-ghost blanking.
- Switches to an animated "win" pattern while the score is at or above a threshold.
- Sits between the game logic (lane shifters, score counter) and the matrix row/column pins.

---
 rtl/led_matrix_scanner.sv | 167 ++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Row-scan driver for the bicolour note-lane LED matrix with frame-synchronous shadow capture and a win animation.
// Optional macro LED_MATRIX_SCANNER_DIM_EN adds a frame-sampled 4-bit brightness input for PWM dimming.
module led_matrix_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int LANES        = 4,
    parameter int SCORE_W      = 8,
    parameter int WIN_SCORE    = 255,
    parameter int HIT_ROW      = 1,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK        = 2,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*ROWS-1:0]  lane_bits,
    input  logic [SCORE_W-1:0]     score,
`ifdef LED_MATRIX_SCANNER_DIM_EN
    input  logic [3:0]             brightness,
`endif
    output logic [ROWS-1:0]        row_sel,
    output logic [COLS-1:0]        red_col,
    output logic [COLS-1:0]        green_col,
    output logic                   frame_start,
    output logic                   win_active
);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BLK_W  = $clog2(BLINK_FRAMES + 1);
    localparam int STRIDE = COLS / LANES;

    localparam logic [SCORE_W-1:0] WIN_THR     = SCORE_W'(WIN_SCORE);
    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]   BLANK_START = DIV_W'(SCAN_DIV - BLANK);
    localparam logic [ROW_W-1:0]   ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]   HIT         = ROW_W'(HIT_ROW);
    localparam logic [BLK_W-1:0]   BLK_LAST    = BLK_W'(BLINK_FRAMES - 1);

    typedef enum logic {NORMAL, WIN} mode_t;

    mode_t                  mode, mode_nxt;
    logic [DIV_W-1:0]       div_cnt_p0;
    logic [ROW_W-1:0]       row_idx_p0;
    logic [LANES*ROWS-1:0]  shadow, shadow_nxt;
    logic                   phase, phase_nxt;
    logic [BLK_W-1:0]       blink_cnt, blink_nxt;
    logic                   boundary_p0, blank_p0;
    logic [ROWS-1:0]        row_sel_p0;
    logic [COLS-1:0]        red_p0, green_p0;
    logic [ROWS-1:0]        lane_col;

    // Stage p0: scan counters
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_p0 <= '0;
            row_idx_p0 <= '0;
        end else if (div_cnt_p0 == DIV_LAST) begin
            div_cnt_p0 <= '0;
            row_idx_p0 <= (row_idx_p0 == ROW_LAST) ? '0 : row_idx_p0 + 1'b1;
        end else begin
            div_cnt_p0 <= div_cnt_p0 + 1'b1;
        end
    end

    assign boundary_p0 = (row_idx_p0 == '0) && (div_cnt_p0 == '0);

`ifdef LED_MATRIX_SCANNER_DIM_EN
    logic [3:0]  bright, bright_nxt;
    logic [31:0] on_lim;

    assign bright_nxt = boundary_p0 ? brightness : bright;
    assign on_lim     = ((32'(bright_nxt) + 32'd1) * 32'(SCAN_DIV)) >> 4;
    assign blank_p0   = (div_cnt_p0 >= BLANK_START) || (32'(div_cnt_p0) >= on_lim);

    always_ff @(posedge clk) begin
        if (reset) bright <= '1;
        else       bright <= bright_nxt;
    end
`else
    assign blank_p0 = (div_cnt_p0 >= BLANK_START);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mode      <= NORMAL;
            shadow    <= '0;
            phase     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            mode      <= mode_nxt;
            shadow    <= shadow_nxt;
            phase     <= phase_nxt;
            blink_cnt <= blink_nxt;
        end
    end

    always_comb begin
        mode_nxt   = mode;
        shadow_nxt = shadow;
        phase_nxt  = phase;
        blink_nxt  = blink_cnt;
        if (boundary_p0) begin
            shadow_nxt = lane_bits;
            case (mode)
                NORMAL:  if (score >= WIN_THR) mode_nxt = WIN;
                WIN:     if (score < WIN_THR)  mode_nxt = NORMAL;
                default: mode_nxt = NORMAL;
            endcase
            if (mode == WIN && mode_nxt == WIN) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_nxt = '0;
                    phase_nxt = ~phase;
                end else begin
                    blink_nxt = blink_cnt + 1'b1;
                end
            end else begin
                blink_nxt = '0;
                phase_nxt = 1'b0;
            end
        end
    end

    // Render from the post-capture view so the first pixel of a frame already uses the freshly loaded data.
    always_comb begin
        row_sel_p0 = '0;
        red_p0     = '0;
        green_p0   = '0;
        lane_col   = '0;
        if (!blank_p0) begin
            row_sel_p0[row_idx_p0] = 1'b1;
            if (mode_nxt == WIN) begin
                for (int c = 0; c < COLS; c++) begin
                    if (row_idx_p0 == '0 || row_idx_p0 == ROW_LAST || c == 0 || c == COLS - 1)
                        green_p0[c] = 1'b1;
                    else
                        red_p0[c] = ~(row_idx_p0[0] ^ phase_nxt ^ (c % 2 == 1));
                end
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    lane_col = shadow_nxt[i*ROWS +: ROWS];
                    if (row_idx_p0 == HIT)
                        green_p0[COLS-1-i*STRIDE] = lane_col[row_idx_p0];
                    else
                        red_p0[COLS-1-i*STRIDE] = lane_col[row_idx_p0];
                end
            end
        end
    end

    // Stage p1: registered matrix drive
    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel     <= '0;
            red_col     <= '0;
            green_col   <= '0;
            frame_start <= 1'b0;
        end else begin
            row_sel     <= row_sel_p0;
            red_col     <= red_p0;
            green_col   <= green_p0;
            frame_start <= boundary_p0;
        end
    end

    assign win_active = (mode == WIN);

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: randomized lane/score stimulus against a frame-level reference model.
module tb_led_matrix_scanner;
    localparam int ROWS = 8, COLS = 8, LANES = 4, SCORE_W = 8;
    localparam int SCAN_DIV = 4, BLANK = 1, BLINK = 2, HIT = 1, WIN_SCORE = 255;
    localparam int FRAME = ROWS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] lane_bits = '0;
    logic [7:0]  score = '0;
    logic [7:0]  row_sel, red_col, green_col;
    logic        frame_start, win_active;
`ifdef LED_MATRIX_SCANNER_DIM_EN
    logic [3:0]  brightness = 4'd15;
`endif

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .LANES(LANES), .SCORE_W(SCORE_W),
        .WIN_SCORE(WIN_SCORE), .HIT_ROW(HIT), .SCAN_DIV(SCAN_DIV),
        .BLANK(BLANK), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lane_bits(lane_bits),
        .score(score),
`ifdef LED_MATRIX_SCANNER_DIM_EN
        .brightness(brightness),
`endif
        .row_sel(row_sel),
        .red_col(red_col),
        .green_col(green_col),
        .frame_start(frame_start),
        .win_active(win_active)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          n = 0;          // scan position (cycles since reset release)
    logic        m_win = 1'b0;   // mode of the current frame
    int          m_run = 0;      // consecutive WIN frames before the current one
    logic [31:0] m_lanes = '0;   // lane data captured for the current frame
    logic [25:0] exp_vec = '0;

    function automatic logic [25:0] observed();
        return {row_sel, red_col, green_col, frame_start, win_active};
    endfunction

    // Picture for scan position pos, derived directly from the pixel rules.
    function automatic logic [23:0] render(int pos);
        int row, dv, ph, col;
        logic [7:0] rs, rd, gr;
        row = (pos / SCAN_DIV) % ROWS;
        dv  = pos % SCAN_DIV;
        rs = '0; rd = '0; gr = '0;
        if (dv < SCAN_DIV - BLANK) begin
            rs[row] = 1'b1;
            if (m_win) begin
                ph = (m_run / BLINK) % 2;
                for (int c = 0; c < COLS; c++) begin
                    if (row == 0 || row == ROWS - 1 || c == 0 || c == COLS - 1) gr[c] = 1'b1;
                    else if ((row + c + ph) % 2 == 0) rd[c] = 1'b1;
                end
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    col = COLS - 1 - i * (COLS / LANES);
                    if (m_lanes[i*ROWS + row]) begin
                        if (row == HIT) gr[col] = 1'b1;
                        else            rd[col] = 1'b1;
                    end
                end
            end
        end
        return {rs, rd, gr};
    endfunction

    // Advance one clock, updating the model with the inputs seen at that edge.
    task automatic tick();
        logic fs;
        @(posedge clk);
        if (reset) begin
            n = 0; m_win = 1'b0; m_run = 0; m_lanes = '0; exp_vec = '0;
        end else begin
            fs = (n % FRAME == 0);
            if (fs) begin
                m_lanes = lane_bits;
                if (score >= WIN_SCORE) begin
                    m_run = m_win ? m_run + 1 : 0;
                    m_win = 1'b1;
                end else begin
                    m_win = 1'b0;
                    m_run = 0;
                end
            end
            exp_vec = {render(n), fs, m_win};
            n++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (observed() !== 26'd0) begin
                failures++; $display("FAIL reset_hold cyc=%0d got=%h want=0", i, observed());
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (frame_start !== 1'b1 || row_sel !== 8'h01) begin
            failures++; $display("FAIL reset_release got fs=%b row_sel=%h want fs=1 row_sel=01", frame_start, row_sel);
        end
        tick();
        checks++;
        if (frame_start !== 1'b0 || row_sel !== 8'h01) begin
            failures++; $display("FAIL reset_next got fs=%b row_sel=%h want fs=0 row_sel=01", frame_start, row_sel);
        end
    endtask

    task automatic test_normal();
        lane_bits = {8'h00, 8'h00, 8'h54, 8'h12};
        score = 8'd55;
        while (n % FRAME != 0) begin
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL normal_lead pos=%0d got=%h want=%h", n - 1, observed(), exp_vec);
            end
        end
        for (int k = 0; k < FRAME; k++) begin
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL normal_scan k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
            if (k == 4) begin
                checks++;
                if (green_col !== 8'h80 || red_col !== 8'h00) begin
                    failures++; $display("FAIL normal_hit_row got g=%h r=%h want g=80 r=00", green_col, red_col);
                end
            end
            if (k == 16) begin
                checks++;
                if (red_col !== 8'hA0 || green_col !== 8'h00) begin
                    failures++; $display("FAIL normal_row4 got r=%h g=%h want r=a0 g=00", red_col, green_col);
                end
            end
            if (k % SCAN_DIV == SCAN_DIV - 1) begin
                checks++;
                if (row_sel !== 8'h00) begin
                    failures++; $display("FAIL normal_blank k=%0d got row_sel=%h want 00", k, row_sel);
                end
            end
        end
        for (int f = 0; f < 3; f++) begin
            lane_bits = $urandom;
            score = 8'($urandom_range(0, 254));
            for (int k = 0; k < FRAME; k++) begin
                tick(); checks++;
                if (observed() !== exp_vec) begin
                    failures++; $display("FAIL normal_rand f=%0d k=%0d got=%h want=%h", f, k, observed(), exp_vec);
                end
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [31:0] oldv;
        oldv = $urandom;
        lane_bits = oldv;
        score = 8'd10;
        for (int k = 0; k < FRAME; k++) begin
            if (k == 9) lane_bits = {$urandom_range(0, 255), 8'hFF} & 32'hFFFF_FFFF | 32'h0000_00FF;
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL midframe k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
            if (k == 12) begin
                checks++;
                if (red_col[7] !== oldv[3]) begin
                    failures++; $display("FAIL midframe_hold got red7=%b want %b", red_col[7], oldv[3]);
                end
            end
        end
        for (int k = 0; k < FRAME; k++) begin
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL midframe_next k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
            if (k == 0) begin
                checks++;
                if (red_col[7] !== 1'b1 || frame_start !== 1'b1) begin
                    failures++; $display("FAIL midframe_new got red7=%b fs=%b want 1 1", red_col[7], frame_start);
                end
            end
        end
    endtask

    task automatic test_win();
        logic [7:0] want_red;
        score = 8'd100;
        for (int k = 0; k < FRAME; k++) begin
            if (k == 5) score = 8'd255;
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL win_pre k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
            if (k > 5) begin
                checks++;
                if (win_active !== 1'b0) begin
                    failures++; $display("FAIL win_early k=%0d got win=%b want 0", k, win_active);
                end
            end
        end
        for (int f = 0; f < 4; f++) begin
            lane_bits = $urandom;
            want_red = (f < 2) ? 8'h2A : 8'h54;
            for (int k = 0; k < FRAME; k++) begin
                tick(); checks++;
                if (observed() !== exp_vec) begin
                    failures++; $display("FAIL win_scan f=%0d k=%0d got=%h want=%h", f, k, observed(), exp_vec);
                end
                if (k == 0) begin
                    checks++;
                    if (win_active !== 1'b1 || green_col !== 8'hFF || red_col !== 8'h00) begin
                        failures++; $display("FAIL win_row0 f=%0d got win=%b g=%h r=%h want 1 ff 00", f, win_active, green_col, red_col);
                    end
                end
                if (k == 4) begin
                    checks++;
                    if (green_col !== 8'h81 || red_col !== want_red) begin
                        failures++; $display("FAIL win_row1 f=%0d got g=%h r=%h want g=81 r=%h", f, green_col, red_col, want_red);
                    end
                end
            end
        end
    endtask

    task automatic test_win_exit();
        for (int k = 0; k < FRAME; k++) begin
            if (k == 7) score = 8'd254;
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL exit_pre k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
            if (k > 7) begin
                checks++;
                if (win_active !== 1'b1) begin
                    failures++; $display("FAIL exit_early k=%0d got win=%b want 1", k, win_active);
                end
            end
        end
        for (int k = 0; k < FRAME; k++) begin
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL exit_scan k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
            if (k == 0) begin
                checks++;
                if (win_active !== 1'b0) begin
                    failures++; $display("FAIL exit_mode got win=%b want 0", win_active);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8 * FRAME; c++) begin
            if ($urandom_range(0, 15) == 0) lane_bits = $urandom;
            if ($urandom_range(0, 23) == 0) score = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom_range(200, 255));
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL b2b c=%0d got=%h want=%h", c, observed(), exp_vec);
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 13; k++) tick();
        reset = 1'b1;
        tick(); checks++;
        if (observed() !== 26'd0) begin
            failures++; $display("FAIL reset_mid got=%h want=0", observed());
        end
        tick();
        reset = 1'b0;
        lane_bits = $urandom;
        score = 8'd255;
        tick(); checks++;
        if (frame_start !== 1'b1 || row_sel !== 8'h01 || win_active !== 1'b1) begin
            failures++; $display("FAIL reset_restart got fs=%b row_sel=%h win=%b want 1 01 1", frame_start, row_sel, win_active);
        end
        for (int k = 1; k < 3 * FRAME; k++) begin
            tick(); checks++;
            if (observed() !== exp_vec) begin
                failures++; $display("FAIL reset_after k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_midframe_change();
        test_win();
        test_win_exit();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
